// File: rtl/adc_spi_pkg.sv
// ============================================================================
// adc_spi_pkg : shared types and constants for the ADC SPI responder
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_spi_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    WAIT_READ = 2'd2,
    SHIFT     = 2'd3
  } state_t;

  localparam int ERR_EARLY = 0;
  localparam int ERR_MOSI  = 1;

  // Mode 0: SCLK idles low, data launched on fall, captured on rise.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : multi-flop synchronizer with registered edge pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // level/rise/fall all update on the same edge, so level_o is coherent with the pulses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(din_i);
      level_o <= sync_q[SYNC_STAGES-1];
      rise_o  <= sync_q[SYNC_STAGES-1] & ~level_o;
      fall_o  <= ~sync_q[SYNC_STAGES-1] & level_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_spi_responder.sv
// ============================================================================
// adc_spi_responder : emulates the external ADC on the SPI read path
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CONV_CYCLES = 35,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic                  sample_req_o,
  input  logic                  cnv_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [1:0]            err_o
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic cnv_rise, cnv_fall, cnv_level_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnv (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(cnv_i),
    .level_o(cnv_level_unused), .rise_o(cnv_rise), .fall_o(cnv_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(spi_clk_i),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(spi_mosi_i),
    .level_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // Launch edge shifts data out, capture edge is where the master samples MOSI/MISO
  logic launch_edge, capture_edge;
  assign launch_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
  assign capture_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cyc_cnt;
  logic [BW-1:0]         bit_cnt;

  assign busy_o = (state == CONVERT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      shreg        <= '0;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      spi_miso_o   <= 1'b0;
      sample_req_o <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 2'b00;
    end else begin
      sample_req_o <= 1'b0;
      frame_done_o <= 1'b0;
      // A new conversion request pre-empts every state, including a frame in flight
      if (cnv_rise) begin
        shreg        <= sample_i;
        sample_req_o <= 1'b1;
        cyc_cnt      <= '0;
        spi_miso_o   <= 1'b0;
        state        <= CONVERT;
      end else begin
        case (state)
          IDLE: spi_miso_o <= 1'b0;
          CONVERT: begin
            if (cnv_fall) begin
              bit_cnt <= '0;
              state   <= SHIFT;
              if (cyc_cnt == CW'(CONV_CYCLES - 1)) begin
                spi_miso_o <= shreg[DATA_WIDTH-1];
              end else begin
                err_o[ERR_EARLY] <= 1'b1;
                shreg            <= '0;
                spi_miso_o       <= 1'b0;
              end
            end else if (cyc_cnt == CW'(CONV_CYCLES - 1)) begin
              state <= WAIT_READ;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          WAIT_READ: begin
            if (cnv_fall) begin
              spi_miso_o <= shreg[DATA_WIDTH-1];
              bit_cnt    <= '0;
              state      <= SHIFT;
            end
          end
          SHIFT: begin
            if (capture_edge && !mosi_level) begin
              err_o[ERR_MOSI] <= 1'b1;
            end
            if (launch_edge) begin
              shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                spi_miso_o   <= 1'b0;
                frame_done_o <= 1'b1;
                state        <= IDLE;
              end else begin
                spi_miso_o <= shreg[DATA_WIDTH-2];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// ============================================================================
// tb_adc_spi_responder : directed SPI-master frames with a scoreboard monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_spi_responder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] sample_i = 16'h0;
  logic        sample_req_o;
  logic        cnv_i = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_mosi_i = 1'b1;
  logic        spi_miso_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [1:0]  err_o;

  adc_spi_responder #(.DATA_WIDTH(16), .CONV_CYCLES(35), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sample_i(sample_i), .sample_req_o(sample_req_o),
    .cnv_i(cnv_i), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  int          sr_cnt = 0;
  logic [15:0] rx_shift = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard side: each frame_done pulse retires one expected frame
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (sample_req_o) sr_cnt++;
      if (frame_done_o) begin
        fd_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_data", 32'(rx_shift), 32'(e.data));
          chk("frame_err", 32'(err_o), 32'(e.err));
        end
      end
    end
  end

  // Mode-0 master: CNV high for conv_clk, then n_falls SCLK periods of 4 high / 4 low
  task automatic do_frame(input logic [15:0] smp, input logic [15:0] smp_late,
                          input int conv_clk, input int bad_rise, input int n_falls,
                          input logic push, input logic [15:0] exp_data,
                          input logic [1:0] exp_err);
    sr_cnt   = 0;
    fd_cnt   = 0;
    sample_i = smp;
    if (push) exp_q.push_back('{data: exp_data, err: exp_err});
    cnv_i = 1'b1;
    repeat (5) tick();
    chk("busy_in_convert", 32'(busy_o), 32'd1);
    sample_i = smp_late;
    repeat (conv_clk - 5) tick();
    cnv_i = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < n_falls; i++) begin
      rx_shift  = {rx_shift[14:0], spi_miso_o};
      spi_clk_i = 1'b1;
      if (i + 1 == bad_rise) spi_mosi_i = 1'b0;
      repeat (4) tick();
      spi_clk_i  = 1'b0;
      spi_mosi_i = 1'b1;
      repeat (4) tick();
    end
    if (n_falls == 16) repeat (6) tick();
    chk("sample_req_count", 32'(sr_cnt), 32'd1);
    chk("frame_done_count", 32'(fd_cnt), (n_falls == 16) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_miso", 32'(spi_miso_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_sample_req", 32'(sample_req_o), 32'd0);
    chk("reset_frame_done", 32'(frame_done_o), 32'd0);
    reset_i = 1'b0;
    repeat (5) tick();

    do_frame(16'hA5C3, 16'hA5C3, 40, 0, 16, 1'b1, 16'hA5C3, 2'b00);

    // Stray SCLK in IDLE must leave MISO low and produce no frame
    fd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      spi_clk_i = 1'b1; repeat (4) tick();
      spi_clk_i = 1'b0; repeat (4) tick();
      chk("idle_sclk_miso", 32'(spi_miso_o), 32'd0);
    end
    chk("idle_sclk_no_frame", 32'(fd_cnt), 32'd0);

    do_frame(16'hFFFE, 16'h0000, 40, 0, 16, 1'b1, 16'hFFFE, 2'b00);
    do_frame(16'hA5C3, 16'hA5C3, 40, 5, 16, 1'b1, 16'hA5C3, 2'b10);
    do_frame(16'h1234, 16'h1234, 10, 0, 16, 1'b1, 16'h0000, 2'b11);
    do_frame(16'h5A5A, 16'h5A5A, 40, 0, 16, 1'b1, 16'h5A5A, 2'b11);

    // Aborted frame followed immediately by a new conversion
    do_frame(16'h1111, 16'h1111, 40, 0, 7, 1'b0, 16'h0, 2'b00);
    do_frame(16'h0F0F, 16'h0F0F, 40, 0, 16, 1'b1, 16'h0F0F, 2'b11);

    // Reset mid-SHIFT with MISO high
    do_frame(16'hFFFF, 16'hFFFF, 40, 0, 5, 1'b0, 16'h0, 2'b00);
    chk("pre_reset_miso", 32'(spi_miso_o), 32'd1);
    fd_cnt  = 0;
    reset_i = 1'b1;
    tick();
    chk("mid_reset_miso", 32'(spi_miso_o), 32'd0);
    chk("mid_reset_busy", 32'(busy_o), 32'd0);
    chk("mid_reset_err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    repeat (10) tick();
    chk("post_reset_no_frame", 32'(fd_cnt), 32'd0);
    chk("post_reset_miso", 32'(spi_miso_o), 32'd0);

    do_frame(16'h8001, 16'h8001, 40, 0, 16, 1'b1, 16'h8001, 2'b00);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI responder that emulates the external ADC on the `ARDUINO_IO[4..7]` interface.
- Lets the FPGA loop a known sample stream back into the existing ADC reading path for on-board and bench self-test without the real converter.
- Responds to CNV/SCLK/MOSI driven by the ADC-reading master and returns a 16-bit two's-complement sample MSB-first on MISO.
- Runs entirely in the 50 MHz `clk_i` domain; SPI inputs are oversampled, not used as clocks.

Parameters:
- DATA_WIDTH, 16, sample width in bits (MSB-first).
- CONV_CYCLES, 35, minimum `clk_i` cycles from CNV rise until data is valid (emulated conversion time).
- SYNC_STAGES, 2, synchronizer flops on each SPI input.

Ports:
- clk_i  in  1  system clock, 50 MHz.
- reset_i  in  1  synchronous, active-high reset.
- sample_i  in  DATA_WIDTH  signed sample to return; captured on detected CNV rise.
- sample_req_o  out  1  one-cycle pulse when sample_i is captured.
- cnv_i  in  1  conversion start / frame select from master.
- spi_clk_i  in  1  SPI clock from master; mode 0, idles low.
- spi_mosi_i  in  1  master MOSI; must be 1 throughout a frame.
- spi_miso_o  out  1  serial data to master.
- busy_o  out  1  high in CONVERT.
- frame_done_o  out  1  one-cycle pulse after last bit is shifted out.
- err_o  out  2  sticky flags: [0] early read (CNV fell before CONV_CYCLES), [1] MOSI low during SHIFT.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register 0; counters 0; err_o cleared (reset is the only way to clear it).
- Input path: each SPI input passes SYNC_STAGES flops, then an edge detector. Edge pulses lag the pin by SYNC_STAGES+1 clk.
- Timing requirement on master: SCLK high and low phases each >= SYNC_STAGES+2 clk cycles. Faster clocks are unsupported.
- MISO is registered. It changes exactly one clk after the internal edge pulse.
- States and transitions:
  - IDLE: on CNV rise, latch sample_i, pulse sample_req_o, clear cycle counter, go to CONVERT.
  - CONVERT: busy_o=1; counter increments each clk.
    - Counter == CONV_CYCLES-1: go to WAIT_READ.
    - CNV fall first: set err_o[0], load shift register with 0, miso=0, go to SHIFT.
  - WAIT_READ: on CNV fall, drive miso = shreg[DATA_WIDTH-1], clear bit count, go to SHIFT.
  - SHIFT: on each SCLK fall, shift left by one, bit count +1, miso = new MSB.
    - On the DATA_WIDTH-th fall: miso=0, pulse frame_done_o, go to IDLE.
    - SCLK rise is ignored, except that MOSI is sampled there; MOSI=0 sets err_o[1].
- Boundary conditions:
  - SCLK edges in IDLE, CONVERT or WAIT_READ are ignored; miso stays 0.
  - CNV rise during SHIFT aborts the frame: no frame_done_o; the new capture proceeds as from IDLE in the same cycle.
  - CNV rise and SCLK fall in the same clk: CNV wins.
  - Fewer than DATA_WIDTH SCLK falls before next CNV rise: remaining bits discarded.
  - Extra SCLK edges after frame end: ignored in IDLE.
  - sample_i changes mid-frame: no effect; only the captured copy is shifted.
  - reset_i mid-frame: immediate return to IDLE, miso=0, no pulses.
- Throughput: one sample per CNV period. Master period must cover CONV_CYCLES + DATA_WIDTH SCLK periods + sync latency.

Decomposition:
- Package adc_spi_pkg holds:
  - DATA_WIDTH default constant.
  - state enum {IDLE, CONVERT, WAIT_READ, SHIFT}.
  - err_o bit index constants ERR_EARLY=0, ERR_MOSI=1.
  - Mode-0 SPI polarity constants shared with the ADC reading master.
- One sub-module: sync_edge_detect (parameter SYNC_STAGES; outputs level_o, rise_o, fall_o). Instantiated for cnv_i, spi_clk_i, spi_mosi_i.
- Remainder is a single FSM + shift register + two counters.

Test Plan:
- Normal frame: sample_i=16'hA5C3; CNV high 40 clk, then low; 16 SCLK cycles, 4 clk high / 4 clk low → bits sampled on rises read 1010_0101_1100_0011; frame_done_o pulses once; err_o=0.
- Negative value: sample_i=-2 (16'hFFFE); sample_i changed to 0 after capture → master reads 16'hFFFE; sample_req_o pulsed exactly once per frame.
- Early read: CNV falls 10 clk after rise (CONV_CYCLES=35) → miso reads 16'h0000; err_o[0]=1, stays set through later good frames until reset.
- MOSI fault: MOSI driven 0 on the 5th SCLK rise → err_o[1]=1; data still 16'hA5C3.
- Abort/reset: CNV rises after 7 SCLK falls → no frame_done_o; next frame returns the new sample. Repeat with reset_i asserted mid-SHIFT → miso=0, busy_o=0, state IDLE on the next clk.
- Loopback: instantiate with the ADC reading master at tick rate 1 MHz; feed a ramp 0,1,2… → master data_o equals the ramp delayed by one frame, no errors over 1000 frames.
